// File: rtl/vga_pkg.sv
// Shared VGA timing constants, framebuffer geometry and RGB332 layout.
// Used by the scan-out stage and the other blocks on the 640x480 path.
package vga_pkg;

  localparam int HPIXELS = 800;
  localparam int VLINES  = 521;
  localparam int HPULSE  = 96;
  localparam int VPULSE  = 2;
  localparam int HBP     = 144;
  localparam int HFP     = 784;
  localparam int VBP     = 31;
  localparam int VFP     = 511;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int SCALE_SH = 2;
  localparam int ADDR_W   = 16;

  localparam int HC_W  = 10;
  localparam int VC_W  = 10;
  localparam int IDX_W = ADDR_W - 1;

  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;

  typedef struct packed {
    logic [R_MSB-R_LSB:0] r;
    logic [G_MSB-G_LSB:0] g;
    logic [B_MSB-B_LSB:0] b;
  } rgb332_t;

  function automatic rgb332_t to_rgb332(input logic [7:0] d);
    rgb332_t p;
    p.r = d[R_MSB:R_LSB];
    p.g = d[G_MSB:G_LSB];
    p.b = d[B_MSB:B_LSB];
    return p;
  endfunction

endpackage

// File: rtl/vga_fb_scanout_if.sv
// Read port between the scan-out stage (master) and the framebuffer RAM (slave).
interface vga_fb_scanout_if;
  import vga_pkg::*;

  // No back-pressure: mem_en qualifies mem_addr in the same cycle, and the
  // RAM must present mem_data for that address on the following cycle.
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;

  modport master (output mem_en, output mem_addr, input mem_data);
  modport slave  (input mem_en, input mem_addr, output mem_data);

endinterface

// File: rtl/vga_raster_cnt.sv
// Horizontal/vertical raster counters with active-window and raw sync decode.
// Outputs are undelayed; callers add whatever pipeline alignment they need.
module vga_raster_cnt
  import vga_pkg::*;
#(
  parameter int H_TOTAL = HPIXELS,
  parameter int V_TOTAL = VLINES,
  parameter int H_PULSE = HPULSE,
  parameter int V_PULSE = VPULSE,
  parameter int H_BP    = HBP,
  parameter int H_FP    = HFP,
  parameter int V_BP    = VBP,
  parameter int V_FP    = VFP
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  output logic [HC_W-1:0] hc_o,
  output logic [VC_W-1:0] vc_o,
  output logic            act_o,
  output logic            v_act_o,
  output logic            hsync_raw_o,
  output logic            vsync_raw_o,
  output logic            line_end_o,
  output logic            frame_end_o
);

  localparam logic [HC_W-1:0] H_LAST  = HC_W'(H_TOTAL - 1);
  localparam logic [VC_W-1:0] V_LAST  = VC_W'(V_TOTAL - 1);
  localparam logic [HC_W-1:0] H_PUL_C = HC_W'(H_PULSE);
  localparam logic [VC_W-1:0] V_PUL_C = VC_W'(V_PULSE);
  localparam logic [HC_W-1:0] H_BP_C  = HC_W'(H_BP);
  localparam logic [HC_W-1:0] H_FP_C  = HC_W'(H_FP);
  localparam logic [VC_W-1:0] V_BP_C  = VC_W'(V_BP);
  localparam logic [VC_W-1:0] V_FP_C  = VC_W'(V_FP);

  logic [HC_W-1:0] hc_q, hc_d;
  logic [VC_W-1:0] vc_q, vc_d;
  logic            h_act;
  logic            v_act;
  logic            line_end;
  logic            frame_end;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  always_comb begin
    line_end  = (hc_q == H_LAST);
    frame_end = line_end && (vc_q == V_LAST);
    hc_d      = line_end ? '0 : hc_q + 1'b1;
    vc_d      = vc_q;
    if (line_end) begin
      vc_d = frame_end ? '0 : vc_q + 1'b1;
    end
    h_act = (hc_q >= H_BP_C) && (hc_q < H_FP_C);
    v_act = (vc_q >= V_BP_C) && (vc_q < V_FP_C);
  end

  assign hc_o        = hc_q;
  assign vc_o        = vc_q;
  assign act_o       = h_act && v_act;
  assign v_act_o     = v_act;
  assign hsync_raw_o = !(hc_q < H_PUL_C);
  assign vsync_raw_o = !(vc_q < V_PUL_C);
  assign line_end_o  = line_end;
  assign frame_end_o = frame_end;

endmodule

// File: rtl/vga_fb_scanout.sv
// 640x480 scan-out: 4x-upscaled RGB332 framebuffer fetch with a fixed 3-cycle
// counter-to-pin latency on every pixel-timed output; buffer swap at frame start.
module vga_fb_scanout
  import vga_pkg::*;
#(
  parameter int H_TOTAL = HPIXELS,
  parameter int V_TOTAL = VLINES,
  parameter int H_PULSE = HPULSE,
  parameter int V_PULSE = VPULSE,
  parameter int H_BP    = HBP,
  parameter int H_FP    = HFP,
  parameter int V_BP    = VBP,
  parameter int V_FP    = VFP,
  parameter int FBW     = FB_W
) (
  input  logic                dclk,
  input  logic                clr_n,
  input  logic                buf_sel,
  vga_fb_scanout_if.master    mem,
  output logic                hsync,
  output logic                vsync,
  output logic [2:0]          red,
  output logic [2:0]          green,
  output logic [1:0]          blue,
  output logic                frame_start,
  output logic                cur_buf
);

  localparam logic [HC_W-1:0]  H_BP_C = HC_W'(H_BP);
  localparam logic [VC_W-1:0]  V_BP_C = VC_W'(V_BP);
  localparam logic [IDX_W-1:0] FBW_C  = IDX_W'(FBW);

  logic [HC_W-1:0] hc;
  logic [VC_W-1:0] vc;
  logic            act;
  logic            v_act;
  logic            hs_raw;
  logic            vs_raw;
  logic            line_end;
  logic            frame_end;

  vga_raster_cnt #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .H_PULSE (H_PULSE),
    .V_PULSE (V_PULSE),
    .H_BP    (H_BP),
    .H_FP    (H_FP),
    .V_BP    (V_BP),
    .V_FP    (V_FP)
  ) u_raster (
    .clk_i       (dclk),
    .rst_n_i     (clr_n),
    .hc_o        (hc),
    .vc_o        (vc),
    .act_o       (act),
    .v_act_o     (v_act),
    .hsync_raw_o (hs_raw),
    .vsync_raw_o (vs_raw),
    .line_end_o  (line_end),
    .frame_end_o (frame_end)
  );

  logic [HC_W-1:0]   h_off;
  logic [VC_W-1:0]   v_off;
  logic [IDX_W-1:0]  idx;
  logic              line_step;
  logic              fs_raw;

  logic [IDX_W-1:0]  line_base_q, line_base_d;
  logic              mem_en_q,    mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic              act_p2_q,    act_p2_d;
  rgb332_t           rgb_q,       rgb_d;
  logic [2:0]        hs_pipe_q,   hs_pipe_d;
  logic [2:0]        vs_pipe_q,   vs_pipe_d;
  logic [2:0]        fs_pipe_q,   fs_pipe_d;
  logic              cur_buf_q,   cur_buf_d;

  always_comb begin
    h_off     = hc - H_BP_C;
    v_off     = vc - V_BP_C;
    idx       = line_base_q + IDX_W'(h_off >> SCALE_SH);
    line_step = v_act && (v_off[SCALE_SH-1:0] == '1);
    fs_raw    = (hc == '0) && (vc == '0);

    // line_base tracks fy*FBW: zero outside the active lines, one framebuffer
    // row further after every 2^SCALE_SH active lines.
    line_base_d = line_base_q;
    if (line_end) begin
      if (!v_act) begin
        line_base_d = '0;
      end else if (line_step) begin
        line_base_d = line_base_q + FBW_C;
      end
    end

    mem_en_d   = act;
    mem_addr_d = mem_addr_q;
    if (act) begin
      mem_addr_d = {cur_buf_q, idx};
    end

    act_p2_d  = mem_en_q;
    rgb_d     = act_p2_q ? to_rgb332(mem.mem_data) : '0;

    // Three-deep delays keep sync and frame_start aligned with the RAM pipeline.
    hs_pipe_d = {hs_pipe_q[1:0], hs_raw};
    vs_pipe_d = {vs_pipe_q[1:0], vs_raw};
    fs_pipe_d = {fs_pipe_q[1:0], fs_raw};

    cur_buf_d = frame_end ? buf_sel : cur_buf_q;
  end

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      line_base_q <= '0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      act_p2_q    <= 1'b0;
      rgb_q       <= '0;
      hs_pipe_q   <= '1;
      vs_pipe_q   <= '1;
      fs_pipe_q   <= '0;
      cur_buf_q   <= 1'b0;
    end else begin
      line_base_q <= line_base_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      act_p2_q    <= act_p2_d;
      rgb_q       <= rgb_d;
      hs_pipe_q   <= hs_pipe_d;
      vs_pipe_q   <= vs_pipe_d;
      fs_pipe_q   <= fs_pipe_d;
      cur_buf_q   <= cur_buf_d;
    end
  end

  assign mem.mem_en   = mem_en_q;
  assign mem.mem_addr = mem_addr_q;
  assign hsync        = hs_pipe_q[2];
  assign vsync        = vs_pipe_q[2];
  assign red          = rgb_q.r;
  assign green        = rgb_q.g;
  assign blue         = rgb_q.b;
  assign frame_start  = fs_pipe_q[2];
  assign cur_buf      = cur_buf_q;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout on a reduced raster so several frames fit a short run;
// the reference model maps elapsed cycles to raster positions arithmetically.
module tb_vga_fb_scanout;

  localparam int HP  = 72;
  localparam int VL  = 30;
  localparam int HPU = 8;
  localparam int VPU = 2;
  localparam int HB  = 12;
  localparam int HF  = 60;
  localparam int VB  = 4;
  localparam int VF  = 28;
  localparam int FW  = 12;
  localparam int FR  = HP * VL;

  logic       dclk;
  logic       clr_n;
  logic       buf_sel;
  logic       hsync;
  logic       vsync;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;
  logic       frame_start;
  logic       cur_buf;

  vga_fb_scanout_if mem_if ();

  vga_fb_scanout #(
    .H_TOTAL (HP),
    .V_TOTAL (VL),
    .H_PULSE (HPU),
    .V_PULSE (VPU),
    .H_BP    (HB),
    .H_FP    (HF),
    .V_BP    (VB),
    .V_FP    (VF),
    .FBW     (FW)
  ) dut (
    .dclk        (dclk),
    .clr_n       (clr_n),
    .buf_sel     (buf_sel),
    .mem         (mem_if.master),
    .hsync       (hsync),
    .vsync       (vsync),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .frame_start (frame_start),
    .cur_buf     (cur_buf)
  );

  // clock / reset block
  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  // synchronous-read framebuffer RAM model
  logic [7:0] ram [0:65535];
  initial mem_if.mem_data = 8'h00;
  always @(posedge dclk) begin
    if (mem_if.mem_en) mem_if.mem_data <= ram[mem_if.mem_addr];
  end

  int          checks;
  int          errors;
  int          t;
  logic [15:0] last_addr;
  bit          bsel_frame [0:15];
  int          hs_low;
  int          vs_low;
  int          last_fs;
  bit          fs_seen;

  // reference model: raster position p counts pixel clocks since (0,0)
  function automatic bit is_act(input int p);
    int hc;
    int vc;
    hc = p % HP;
    vc = (p / HP) % VL;
    return (hc >= HB) && (hc < HF) && (vc >= VB) && (vc < VF);
  endfunction

  function automatic logic [15:0] addr_of(input int p, input bit b);
    int hc;
    int vc;
    int idx;
    hc  = p % HP;
    vc  = (p / HP) % VL;
    idx = ((vc - VB) / 4) * FW + (hc - HB) / 4;
    return {b, 15'(idx)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hsync"}, 32'(hsync), 32'd1);
    check({tag, "_vsync"}, 32'(vsync), 32'd1);
    check({tag, "_rgb"}, 32'({red, green, blue}), 32'd0);
    check({tag, "_mem_en"}, 32'(mem_if.mem_en), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_if.mem_addr), 32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check({tag, "_cur_buf"}, 32'(cur_buf), 32'd0);
  endtask

  task automatic model_reset();
    t         = 0;
    last_addr = 16'h0000;
    for (int i = 0; i < 16; i++) bsel_frame[i] = 1'b0;
    hs_low    = 0;
    vs_low    = 0;
    last_fs   = 0;
    fs_seen   = 1'b0;
  endtask

  // checks for the current cycle t, then drive buf_sel for this cycle
  task automatic cycle_body();
    bit          e_en;
    logic [7:0]  e_rgb;
    bit          e_hs;
    bit          e_vs;
    bit          e_fs;
    e_en = (t >= 1) && is_act(t - 1);
    if (e_en) last_addr = addr_of(t - 1, bsel_frame[(t - 1) / FR]);
    e_rgb = 8'h00;
    if ((t >= 3) && is_act(t - 3)) e_rgb = ram[addr_of(t - 3, bsel_frame[(t - 3) / FR])];
    e_hs = (t < 3) ? 1'b1 : !(((t - 3) % HP) < HPU);
    e_vs = (t < 3) ? 1'b1 : !((((t - 3) / HP) % VL) < VPU);
    e_fs = (t >= 3) && (((t - 3) % FR) == 0);

    check("mem_en", 32'(mem_if.mem_en), 32'(e_en));
    check("mem_addr", 32'(mem_if.mem_addr), 32'(last_addr));
    check("rgb", 32'({red, green, blue}), 32'(e_rgb));
    check("hsync", 32'(hsync), 32'(e_hs));
    check("vsync", 32'(vsync), 32'(e_vs));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("cur_buf", 32'(cur_buf), 32'(bsel_frame[t / FR]));

    if (t >= 3) begin
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (((t - 3) % HP) == HP - 1) begin
        check("hsync_low_per_line", 32'(hs_low), 32'(HPU));
        hs_low = 0;
      end
      if (((t - 3) % FR) == FR - 1) begin
        check("vsync_low_per_frame", 32'(vs_low), 32'(VPU * HP));
        vs_low = 0;
      end
    end
    if (frame_start) begin
      if (!fs_seen) check("first_frame_start_delay", 32'(t), 32'd3);
      else          check("frame_period", 32'(t - last_fs), 32'(FR));
      fs_seen = 1'b1;
      last_fs = t;
    end

    if ($urandom_range(0, 299) == 0) buf_sel = ~buf_sel;
    if ((t % FR) == FR - 1) bsel_frame[t / FR + 1] = buf_sel;
  endtask

  task automatic step();
    @(posedge dclk);
    #1;
    t++;
    cycle_body();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    clr_n   = 1'b0;
    buf_sel = 1'b0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    model_reset();

    // power-on reset
    repeat (3) @(posedge dclk);
    #1;
    check_reset_vals("por");
    @(posedge dclk);
    #3;
    clr_n = 1'b1;
    model_reset();
    #1;
    cycle_body();

    // four frames with random buffer requests
    repeat (4 * FR) step();

    // reset mid-frame, asynchronously
    repeat (15 * HP + 40) step();
    @(posedge dclk);
    #3;
    clr_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    repeat (3) begin
      @(posedge dclk);
      #1;
      check_reset_vals("held_rst");
    end
    @(posedge dclk);
    #3;
    clr_n = 1'b1;
    model_reset();
    #1;
    cycle_body();

    // restart after reset, three more frames
    repeat (3 * FR + 10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fb_scanout.md
Name: vga_fb_scanout

Overview:
- Scan-out stage for the 640x480 VGA path. Generates its own 800x521 raster counters and fetches pixels from an external synchronous-read framebuffer RAM, 160x120 RGB332, upscaled 4x in both axes.
- Drives hsync/vsync/red/green/blue to the pins, with sync delayed so sync and colour stay pixel-aligned across the RAM pipeline.
- Supports double buffering; the buffer swap is latched only at frame start.

Parameters:
- HPIXELS, 800, pixel clocks per line
- VLINES, 521, lines per frame
- HPULSE, 96, hsync low width (clocks)
- VPULSE, 2, vsync low width (lines)
- HBP, 144, first active hc
- HFP, 784, first hc after active video
- VBP, 31, first active vc
- VFP, 511, first vc after active video
- FB_W, 160, framebuffer width (pixels)
- FB_H, 120, framebuffer height (lines)
- SCALE_SH, 2, log2 of the upscale factor
- ADDR_W, 16, mem_addr width (MSB = buffer select, lower 15 bits = pixel index)

Ports:
- dclk  in  1  pixel clock, 25 MHz
- clr_n  in  1  asynchronous reset, active low
- buf_sel  in  1  requested display buffer; sampled at frame start
- mem_en  out  1  RAM read enable
- mem_addr  out  ADDR_W  RAM read address
- mem_data  in  8  RAM read data {r[2:0],g[2:0],b[1:0]}, valid the cycle after mem_en
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- red  out  3  red output
- green  out  3  green output
- blue  out  2  blue output
- frame_start  out  1  one-cycle pulse, aligned with the output of pixel (hc=0, vc=0)
- cur_buf  out  1  buffer currently displayed

Behaviour:
- Reset (clr_n=0, async): hc=vc=0; all pipeline registers cleared; hsync=vsync=1; rgb=0; mem_en=0; mem_addr=0; frame_start=0; cur_buf=0.
- Counters:
  - hc runs 0..HPIXELS-1; on wrap hc=0 and vc increments.
  - vc runs 0..VLINES-1 and wraps to 0.
- Stage 0, combinational from hc/vc:
  - act = (HBP<=hc<HFP) and (VBP<=vc<VFP)
  - fx = (hc-HBP)>>SCALE_SH, range 0..159
  - fy = (vc-VBP)>>SCALE_SH, range 0..119
  - idx = fy*FB_W+fx
  - A multiplier is not required: a running line base (+FB_W every 2^SCALE_SH active lines, cleared at vc=VBP) is an acceptable implementation provided the result is identical.
- Stage 1 (registered): mem_en=act; mem_addr={cur_buf, idx[14:0]}. When act=0, mem_addr holds its previous value.
- Stage 2: RAM returns mem_data.
- Stage 3 (registered outputs): rgb = mem_data when delayed act=1, else 0.
- hsync = !(hc<HPULSE) and vsync = !(vc<VPULSE), each delayed 3 cycles through shift registers.
- Fixed latency: outputs in cycle N+3 correspond to hc/vc in cycle N, for all outputs.
- Buffer select:
  - cur_buf <= buf_sel at the clock edge where hc=HPIXELS-1 and vc=VLINES-1, so it takes effect from (0,0).
  - buf_sel changes at any other time have no effect until the next frame boundary; no tearing.
- frame_start: 1 in the output cycle corresponding to (0,0), else 0.
- Address range: idx is at most 19199; addresses above that are never issued.
- Reset mid-frame: immediate return to reset values; the first valid frame restarts at (0,0), with the first frame_start 3 cycles after the reset release.

Decomposition:
- Shared package vga_pkg:
  - timing constants HPIXELS..VFP (shared with the existing colour-bar generator)
  - FB_W, FB_H
  - RGB332 field positions
- One sub-module, vga_raster_cnt:
  - hc/vc counters plus act, hsync_raw and vsync_raw
  - reusable by the other VGA blocks
- Address generation, delay line and buffer latch stay in the top module.

Test Plan:
- Reset release with a RAM model returning data=addr[7:0] → first frame_start exactly 3 clocks after release; vsync low for 1600 clocks per frame; period 416800 clocks.
- Pixel at hc=144, vc=31 → mem_addr=0x0000 one cycle later; rgb=mem_data[0] 3 cycles after the counter; hc=148 → addr 1; vc=35, hc=144 → addr 160.
- Last active pixel hc=783, vc=510 → addr 19199 (0x4AFF); hc=784 → mem_en=0 and rgb=0 three cycles later.
- Toggle buf_sel 0→1 mid-frame at vc=200 → mem_addr[15] stays 0 for the rest of the frame; becomes 1 from vc=31 of the next frame; cur_buf flips on the edge at hc=799, vc=520.
- Assert clr_n=0 at hc=400, vc=300 → outputs go to reset values immediately, asynchronously; after release the counters restart at 0 and the sync period is exact.
- Over 2 frames, hsync low exactly 96 clocks per 800 clocks; rgb nonzero only inside the delayed active window; the scoreboard compares against a golden model of the 3-cycle latency.
